// File: rtl/raifes_per_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : raifes_per_bus_arbiter
// Purpose  : Two-master / one-slave HASTI (AHB-lite) arbiter for the
//            peripheral bus. Master 0 is the core data port and master 1 is
//            the debug system-bus port. The arbiter grants the shared address
//            phase, remembers who owns the data phase, and routes write data,
//            read data, ready and response. Nothing is buffered: a losing
//            master is held off by driving its hready low.
// Ports    :
//   clk, nreset                    clock, asynchronous active-low reset
//   mN_haddr/hwrite/hsize/htrans   master N address phase (N = 0, 1)
//   mN_hwdata                      master N write data
//   mN_hrdata/hready/hresp         read data, ready, response to master N
//   per_haddr/hwrite/hsize/htrans  slave address phase
//   per_hwdata                     slave write data
//   per_hrdata/hready/hresp        slave read data, ready, response
// Params   :
//   MAX_WAIT      stalled cycles before the low-priority master is boosted
//   M1_HIGH_PRIO  1: master 1 wins ties, 0: master 0 wins ties
// Revision : 1.0 - initial release
// ============================================================================
module raifes_per_bus_arbiter #(
   parameter int unsigned MAX_WAIT     = 8,
   parameter bit          M1_HIGH_PRIO = 1'b1
) (
   input  logic        clk,
   input  logic        nreset,
   // master 0
   input  logic [31:0] m0_haddr,
   input  logic        m0_hwrite,
   input  logic [2:0]  m0_hsize,
   input  logic [1:0]  m0_htrans,
   input  logic [31:0] m0_hwdata,
   output logic [31:0] m0_hrdata,
   output logic        m0_hready,
   output logic        m0_hresp,
   // master 1
   input  logic [31:0] m1_haddr,
   input  logic        m1_hwrite,
   input  logic [2:0]  m1_hsize,
   input  logic [1:0]  m1_htrans,
   input  logic [31:0] m1_hwdata,
   output logic [31:0] m1_hrdata,
   output logic        m1_hready,
   output logic        m1_hresp,
   // slave
   output logic [31:0] per_haddr,
   output logic        per_hwrite,
   output logic [2:0]  per_hsize,
   output logic [1:0]  per_htrans,
   output logic [31:0] per_hwdata,
   input  logic [31:0] per_hrdata,
   input  logic        per_hready,
   input  logic        per_hresp
);

   localparam logic [1:0] c_HTRANS_IDLE = 2'b00;
   localparam logic       c_LP_MST      = ~M1_HIGH_PRIO;   // low-priority master index
   localparam logic [7:0] c_MAX_WAIT    = 8'(MAX_WAIT);

   // registered state
   logic       r_last_own;
   logic       r_dp_valid;
   logic       r_dp_own;
   logic [7:0] r_cnt;
   logic       r_boost;

   // combinational arbitration
   logic       w_req0;
   logic       w_req1;
   logic       w_lock;
   logic       w_addr_own;
   logic       w_addr_req;
   logic       w_addr_drive;
   logic       w_dp_act0;
   logic       w_dp_act1;
   logic       w_own0;
   logic       w_own1;
   logic       w_lp_req;
   logic       w_lp_grant;
   logic       w_lp_stall;

   // NONSEQ and SEQ both have htrans[1] set
   assign w_req0 = m0_htrans[1];
   assign w_req1 = m1_htrans[1];

   // SEQ (11) and BUSY (01) share htrans[0]: the previous owner is mid-burst
   assign w_lock = r_last_own ? m1_htrans[0] : m0_htrans[0];

   always_comb begin
      w_addr_own = r_last_own;                  // park on the last owner
      if (!w_lock) begin
         if (w_req0 && !w_req1) begin
            w_addr_own = 1'b0;
         end else if (w_req1 && !w_req0) begin
            w_addr_own = 1'b1;
         end else if (w_req0 && w_req1) begin
            w_addr_own = r_boost ? c_LP_MST : M1_HIGH_PRIO;
         end
      end
   end

   assign w_addr_req   = w_addr_own ? w_req1 : w_req0;
   // a locked owner may be in BUSY, which is forwarded but opens no data phase
   assign w_addr_drive = w_addr_req | w_lock;

   // slave address phase
   assign per_haddr  = w_addr_own ? m1_haddr  : m0_haddr;
   assign per_hwrite = w_addr_own ? m1_hwrite : m0_hwrite;
   assign per_hsize  = w_addr_own ? m1_hsize  : m0_hsize;
   assign per_htrans = (nreset && w_addr_drive) ?
                       (w_addr_own ? m1_htrans : m0_htrans) : c_HTRANS_IDLE;

   // data phase routing
   assign per_hwdata = r_dp_own ? m1_hwdata : m0_hwdata;
   assign m0_hrdata  = per_hrdata;
   assign m1_hrdata  = per_hrdata;

   assign w_dp_act0 = r_dp_valid & ~r_dp_own;
   assign w_dp_act1 = r_dp_valid &  r_dp_own;
   assign w_own0    = ~w_addr_own & w_addr_drive;
   assign w_own1    =  w_addr_own & w_addr_drive;

   // Data-phase owner and address-phase owner follow the slave; a master that
   // requests without the grant is stalled; an idle bystander sees ready.
   // While nreset is low every master sees ready/OKAY.
   assign m0_hready = ~nreset | ((w_dp_act0 | w_own0) ? per_hready : ~w_req0);
   assign m1_hready = ~nreset | ((w_dp_act1 | w_own1) ? per_hready : ~w_req1);
   assign m0_hresp  = nreset & w_dp_act0 & per_hresp;
   assign m1_hresp  = nreset & w_dp_act1 & per_hresp;

   // starvation tracking for the low-priority master
   assign w_lp_req   = c_LP_MST ? w_req1 : w_req0;
   assign w_lp_grant = per_hready & w_lp_req & (w_addr_own == c_LP_MST);
   assign w_lp_stall = w_lp_req & (w_addr_own != c_LP_MST);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_last_own <= M1_HIGH_PRIO;
         r_dp_valid <= 1'b0;
         r_dp_own   <= 1'b0;
         r_cnt      <= 8'd0;
         r_boost    <= 1'b0;
      end else begin
         if (per_hready) begin
            r_last_own <= w_addr_own;
            r_dp_valid <= w_addr_req;
            r_dp_own   <= w_addr_own;
         end
         if (w_lp_grant) begin
            r_cnt   <= 8'd0;
            r_boost <= 1'b0;
         end else if (w_lp_stall) begin
            // saturate at the threshold; boost once MAX_WAIT stalls are seen
            if (r_cnt != c_MAX_WAIT) begin
               r_cnt <= r_cnt + 8'd1;
            end
            if (r_cnt >= c_MAX_WAIT - 8'd1) begin
               r_boost <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_raifes_per_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_raifes_per_bus_arbiter
// Purpose  : Self-checking bench for raifes_per_bus_arbiter. Directed
//            sequences for reset, single master, collision, burst lock,
//            starvation boost, slave wait/ERROR and asynchronous reset, plus a
//            randomized phase in which both masters issue non-pipelined reads
//            and writes to private address windows of a slave memory model.
//            Expected read data comes from a per-master reference memory
//            updated in program order; a separate monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raifes_per_bus_arbiter;

   localparam int MAX_WAIT = 8;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic [31:0] haddr  [2];
   logic        hwrite [2];
   logic [2:0]  hsize  [2];
   logic [1:0]  htrans [2];
   logic [31:0] hwdata [2];
   logic [31:0] hrdata [2];
   logic        hready [2];
   logic        hresp  [2];
   logic [31:0] per_haddr;
   logic        per_hwrite;
   logic [2:0]  per_hsize;
   logic [1:0]  per_htrans;
   logic [31:0] per_hwdata;
   logic [31:0] per_hrdata;
   logic        per_hready;
   logic        per_hresp;

   int n_chk  = 0;
   int n_fail = 0;

   // randomized-phase state
   txn_t        sbq [2][$];
   txn_t        mt;
   logic [31:0] refm [2][16];
   logic [31:0] smem [32];
   logic [31:0] cur_d [2];
   int          st [2];
   int          gap [2];
   int          wt [2];
   int          maxw = 0;
   bit          rnd_on = 1'b0;
   bit          slv_auto = 1'b0;

   always #5 clk = ~clk;

   raifes_per_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .M1_HIGH_PRIO(1'b1)) dut (
      .clk(clk), .nreset(nreset),
      .m0_haddr(haddr[0]), .m0_hwrite(hwrite[0]), .m0_hsize(hsize[0]),
      .m0_htrans(htrans[0]), .m0_hwdata(hwdata[0]), .m0_hrdata(hrdata[0]),
      .m0_hready(hready[0]), .m0_hresp(hresp[0]),
      .m1_haddr(haddr[1]), .m1_hwrite(hwrite[1]), .m1_hsize(hsize[1]),
      .m1_htrans(htrans[1]), .m1_hwdata(hwdata[1]), .m1_hrdata(hrdata[1]),
      .m1_hready(hready[1]), .m1_hresp(hresp[1]),
      .per_haddr(per_haddr), .per_hwrite(per_hwrite), .per_hsize(per_hsize),
      .per_htrans(per_htrans), .per_hwdata(per_hwdata), .per_hrdata(per_hrdata),
      .per_hready(per_hready), .per_hresp(per_hresp)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input int n, input logic [1:0] t, input logic [31:0] a, input logic w);
      htrans[n] = t;
      haddr[n]  = a;
      hwrite[n] = w;
      hsize[n]  = 3'd2;
   endtask

   function automatic int sidx_of(input logic [31:0] a);
      return int'({a[28], a[5:2]});
   endfunction

   // start one random transfer on master n and record what it must return
   task automatic issue(input int n);
      int   k;
      txn_t t;
      k      = int'($urandom_range(0, 15));
      t.a    = (n == 1 ? 32'h3000_0000 : 32'h2000_0000) + 32'(k * 4);
      t.w    = 1'($urandom_range(0, 1));
      cur_d[n] = $urandom;
      t.d    = t.w ? cur_d[n] : refm[n][k];
      if (t.w) refm[n][k] = cur_d[n];
      sbq[n].push_back(t);
      drv(n, 2'b10, t.a, t.w);
      st[n] = 1;
      wt[n] = 0;
   endtask

   // slave memory model with random wait states (randomized phase only)
   initial begin : slave_model
      logic        s_acc, s_req, s_w, sdv, sw;
      logic [31:0] s_a, s_wd;
      int          si;
      s_acc = 1'b0; s_req = 1'b0; s_w = 1'b0; sdv = 1'b0; sw = 1'b0;
      s_a = '0; s_wd = '0; si = 0;
      forever begin
         @(negedge clk);
         if (slv_auto) begin
            s_acc = per_hready;
            s_req = per_htrans[1];
            s_a   = per_haddr;
            s_w   = per_hwrite;
            s_wd  = per_hwdata;
         end
         @(posedge clk);
         #1;
         if (slv_auto) begin
            if (s_acc) begin
               if (sdv && sw) smem[si] = s_wd;
               sdv = s_req;
               si  = sidx_of(s_a);
               sw  = s_w;
               if (sdv && !sw) per_hrdata = smem[si];
            end
            if (sdv) per_hready = ($urandom_range(0, 3) != 0);
            else     per_hready = 1'b1;
            s_acc = 1'b0;
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (rnd_on) begin
         for (int n = 0; n < 2; n++) begin
            if (st[n] == 2 && hready[n]) begin
               if (sbq[n].size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_underflow m%0d: got completion expected none", n);
               end else begin
                  mt = sbq[n].pop_front();
                  if (!mt.w) chk($sformatf("rd_m%0d_%h", n, mt.a), hrdata[n], mt.d);
                  chk($sformatf("rsp_m%0d", n), 32'(hresp[n]), 0);
               end
            end
         end
         if (!htrans[0][1] && !htrans[1][1]) chk("idle_htrans", 32'(per_htrans), 0);
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          lo, er, stalls;
      bit          won;
      bit          rs [2];
      logic [31:0] a1;

      for (int i = 0; i < 32; i++) smem[i] = 32'hA5A5_0000 | 32'(i);
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < 16; k++) refm[n][k] = 32'hA5A5_0000 | 32'(n * 16 + k);
         st[n] = 0; gap[n] = 0; wt[n] = 0; cur_d[n] = '0;
         hwdata[n] = '0;
         drv(n, 2'b10, 32'h0, 1'b0);       // requesting while held in reset
      end
      per_hready = 1'b1; per_hresp = 1'b0; per_hrdata = '0;
      nreset = 1'b0;

      // ---------------- reset state
      #3;
      chk("rst_per_htrans", 32'(per_htrans), 0);
      chk("rst_m0_hready", 32'(hready[0]), 1);
      chk("rst_m1_hready", 32'(hready[1]), 1);
      chk("rst_m0_hresp", 32'(hresp[0]), 0);
      chk("rst_m1_hresp", 32'(hresp[1]), 0);
      drv(0, 2'b00, 32'h0, 1'b0);
      drv(1, 2'b00, 32'h0, 1'b0);
      @(negedge clk);
      nreset = 1'b1;
      step();

      // ---------------- single master write
      drv(0, 2'b10, 32'h8000_0010, 1'b1);
      smp();
      chk("sm_addr", per_haddr, 32'h8000_0010);
      chk("sm_write", 32'(per_hwrite), 1);
      chk("sm_m0_rdy", 32'(hready[0]), 1);
      chk("sm_m1_rdy", 32'(hready[1]), 1);
      step();
      drv(0, 2'b00, 32'h0, 1'b0);
      hwdata[0] = 32'hDEAD_BEEF;
      smp();
      chk("sm_wdata", per_hwdata, 32'hDEAD_BEEF);
      chk("sm_m0_rdy_dp", 32'(hready[0]), 1);
      chk("sm_m1_rdy_dp", 32'(hready[1]), 1);
      step();

      // ---------------- collision, master 1 has priority
      drv(0, 2'b10, 32'h100, 1'b0);
      drv(1, 2'b10, 32'h200, 1'b0);
      smp();
      chk("col_addr1", per_haddr, 32'h200);
      chk("col_m0_stall", 32'(hready[0]), 0);
      chk("col_m1_rdy", 32'(hready[1]), 1);
      step();
      drv(1, 2'b00, 32'h0, 1'b0);
      per_hrdata = 32'h1111_1111;
      smp();
      chk("col_addr2", per_haddr, 32'h100);
      chk("col_m0_rdy", 32'(hready[0]), 1);
      chk("col_m1_dp_rdy", 32'(hready[1]), 1);
      chk("col_m1_rdata", hrdata[1], 32'h1111_1111);
      step();
      drv(0, 2'b00, 32'h0, 1'b0);
      per_hrdata = 32'h2222_2222;
      smp();
      chk("col_m0_rdata", hrdata[0], 32'h2222_2222);
      chk("col_m0_dp_rdy", 32'(hready[0]), 1);
      step();

      // ---------------- burst lock
      drv(0, 2'b10, 32'h0, 1'b0);
      smp();
      chk("bl_addr0", per_haddr, 32'h0);
      for (int i = 1; i < 4; i++) begin
         step();
         drv(0, 2'b11, 32'(i * 4), 1'b0);
         drv(1, 2'b10, 32'h200, 1'b0);
         smp();
         chk($sformatf("bl_addr%0d", i), per_haddr, 32'(i * 4));
         chk($sformatf("bl_m1_stall%0d", i), 32'(hready[1]), 0);
      end
      step();
      drv(0, 2'b00, 32'h0, 1'b0);
      smp();
      chk("bl_m1_addr", per_haddr, 32'h200);
      chk("bl_m1_rdy", 32'(hready[1]), 1);
      step();
      drv(1, 2'b00, 32'h0, 1'b0);
      step();

      // ---------------- starvation boost (two rounds: boost then cleared)
      a1 = 32'h1000;
      drv(1, 2'b10, a1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         stalls = 0;
         won    = 1'b0;
         step();
         a1 += 4;
         drv(1, 2'b10, a1, 1'b0);
         drv(0, 2'b10, 32'h500, 1'b0);
         for (int i = 0; i < 40 && !won; i++) begin
            if (i > 0) begin
               step();
               a1 += 4;
               drv(1, 2'b10, a1, 1'b0);
            end
            smp();
            if (hready[0]) begin
               won = 1'b1;
               chk($sformatf("sv_addr_r%0d", r), per_haddr, 32'h500);
            end else begin
               stalls++;
            end
         end
         n_chk++;
         if (!won || stalls < MAX_WAIT || stalls > MAX_WAIT + 1) begin
            n_fail++;
            $display("FAIL sv_stalls_r%0d: got won=%0d stalls=%0d expected won=1 stalls %0d..%0d",
                     r, won, stalls, MAX_WAIT, MAX_WAIT + 1);
         end
         step();
         a1 += 4;
         drv(1, 2'b10, a1, 1'b0);
         drv(0, 2'b00, 32'h0, 1'b0);
      end
      step();
      drv(1, 2'b00, 32'h0, 1'b0);
      step();
      step();

      // ---------------- slave wait states then ERROR on a master 1 read
      drv(1, 2'b10, 32'h300, 1'b0);
      smp();
      chk("er_m1_addr_rdy", 32'(hready[1]), 1);
      step();
      drv(1, 2'b00, 32'h0, 1'b0);
      drv(0, 2'b10, 32'h400, 1'b0);
      per_hready = 1'b0;
      per_hresp  = 1'b0;
      lo = 0;
      er = 0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         if (i == 2) begin per_hready = 1'b0; per_hresp = 1'b1; end
         if (i == 3) begin per_hready = 1'b1; per_hresp = 1'b1; end
         smp();
         lo += hready[1] ? 0 : 1;
         er += hresp[1] ? 1 : 0;
         chk($sformatf("er_m0_hresp%0d", i), 32'(hresp[0]), 0);
      end
      chk("er_m1_low_cycles", lo, 2 + 1);
      chk("er_m1_err_cycles", er, 2);
      chk("er_m0_accept", 32'(hready[0]), 1);
      step();
      per_hresp = 1'b0;
      drv(0, 2'b00, 32'h0, 1'b0);
      step();
      step();

      // ---------------- randomized scoreboard phase
      slv_auto = 1'b1;
      rnd_on   = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         smp();
         rs[0] = hready[0];
         rs[1] = hready[1];
         step();
         for (int n = 0; n < 2; n++) begin
            case (st[n])
               0: begin
                  if (gap[n] > 0) gap[n]--;
                  else if (c < 2800) issue(n);
               end
               1: begin
                  if (rs[n]) begin
                     drv(n, 2'b00, haddr[n], 1'b0);
                     hwdata[n] = cur_d[n];
                     st[n] = 2;
                  end else begin
                     wt[n]++;
                     if (wt[n] > maxw) maxw = wt[n];
                  end
               end
               default: begin
                  if (rs[n]) begin
                     st[n]  = 0;
                     gap[n] = int'($urandom_range(0, 3));
                  end
               end
            endcase
         end
      end
      rnd_on   = 1'b0;
      slv_auto = 1'b0;
      per_hready = 1'b1;
      per_hresp  = 1'b0;
      chk("rnd_drained", st[0] + st[1], 0);
      chk("rnd_sb_empty", sbq[0].size() + sbq[1].size(), 0);
      n_chk++;
      if (maxw > 64) begin
         n_fail++;
         $display("FAIL rnd_addr_wait: got %0d cycles expected at most 64", maxw);
      end
      step();

      // ---------------- asynchronous reset during a data phase
      drv(1, 2'b10, 32'h3000_0004, 1'b0);
      smp();
      step();
      drv(1, 2'b00, 32'h0, 1'b0);
      drv(0, 2'b10, 32'h2000_0000, 1'b0);
      per_hready = 1'b0;
      per_hresp  = 1'b1;
      smp();
      chk("ar_m1_wait", 32'(hready[1]), 0);
      chk("ar_m1_resp_pre", 32'(hresp[1]), 1);
      @(posedge clk);
      #3;
      nreset = 1'b0;
      #1;
      chk("ar_per_htrans", 32'(per_htrans), 0);
      chk("ar_m0_rdy", 32'(hready[0]), 1);
      chk("ar_m1_rdy", 32'(hready[1]), 1);
      chk("ar_m1_resp", 32'(hresp[1]), 0);
      @(negedge clk);
      nreset = 1'b1;
      #1;
      chk("ar_m1_no_cpl_rdy", 32'(hready[1]), 1);
      chk("ar_m1_no_cpl_resp", 32'(hresp[1]), 0);
      drv(0, 2'b00, 32'h0, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
